// File: rtl/prbs_pkg.sv
// PRBS31 definitions shared by the generator and checker (x^31 + x^28 + 1).
package prbs_pkg;
    localparam int PRBS31_LEN    = 31;
    localparam int PRBS31_TAP_HI = 30;
    localparam int PRBS31_TAP_LO = 27;

    typedef enum logic [1:0] {SEED, VERIFY, LOCKED} prbs_state_e;

    // hist[0] is the newest bit; the next bit of a clean stream is s[n-31] ^ s[n-28].
    function automatic logic prbs31_predict(input logic [PRBS31_LEN-1:0] hist);
        return hist[PRBS31_TAP_HI] ^ hist[PRBS31_TAP_LO];
    endfunction
endpackage

// File: rtl/prbs31_checker_if.sv
// Serial receive bus between a bit source and the PRBS31 checker.
interface prbs31_checker_if #(parameter int ERR_W = 16);
    logic             din;
    logic             din_valid;
    logic             err_clear;
    logic             locked;
    logic             err_pulse;
    logic [ERR_W-1:0] err_count;

    modport master (output din, din_valid, err_clear,
                    input  locked, err_pulse, err_count);
    modport slave  (input  din, din_valid, err_clear,
                    output locked, err_pulse, err_count);
endinterface

// File: rtl/prbs_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module prbs_sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] cnt
);
    logic [WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (inc && (cnt_q != '1))
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;
endmodule

// File: rtl/prbs31_checker.sv
// PRBS31 receive checker: self-synchronises, locks, counts errors and re-hunts on loss.
// Define PRBS_FREEWHEEL_EN to let the local LFSR freewheel while locked.
module prbs31_checker
    import prbs_pkg::*;
#(
    parameter int LOCK_MATCH  = 64,
    parameter int WIN_LEN     = 128,
    parameter int LOSS_THRESH = 16,
    parameter int ERR_W       = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    prbs31_checker_if.slave bus
);
    localparam int SEED_W  = $clog2(PRBS31_LEN + 1);
    localparam int MATCH_W = $clog2(LOCK_MATCH + 1);
    localparam int WIN_W   = $clog2(WIN_LEN + 1);
    localparam int WERR_W  = $clog2(LOSS_THRESH + 1);
    localparam int ZRUN_W  = $clog2(PRBS31_LEN + 1);

    localparam logic [SEED_W-1:0]  SEED_LAST  = SEED_W'(PRBS31_LEN - 1);
    localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_MATCH - 1);
    localparam logic [WIN_W-1:0]   WIN_LAST   = WIN_W'(WIN_LEN - 1);
    localparam logic [WERR_W-1:0]  THRESH     = WERR_W'(LOSS_THRESH);
    localparam logic [ZRUN_W-1:0]  ZRUN_MAX   = ZRUN_W'(PRBS31_LEN);

    prbs_state_e           state_q, state_d;
    logic [PRBS31_LEN-1:0] hist_q, hist_d;
    logic [SEED_W-1:0]     seed_cnt_q, seed_cnt_d;
    logic [MATCH_W-1:0]    match_cnt_q, match_cnt_d;
    logic [WIN_W-1:0]      win_cnt_q, win_cnt_d;
    logic [WERR_W-1:0]     win_err_q, win_err_d, win_err_nxt;
    logic [ZRUN_W-1:0]     zrun_q, zrun_d;
    logic                  locked_q, locked_d;
    logic                  err_pulse_q, err_pulse_d;
    logic [ERR_W-1:0]      err_count;

    logic pred, bit_err, shift_bit;
    logic seed_done, verify_fail, verify_done, err_hit, lock_loss, win_end, zrun_hit;

    // Per-bit qualifiers shared by the next-state and datapath logic.
    always_comb begin
        pred    = prbs31_predict(hist_q);
        bit_err = bus.din ^ pred;
        zrun_d  = zrun_q;
        if (bus.din_valid) begin
            if (bus.din)
                zrun_d = '0;
            else if (zrun_q != ZRUN_MAX)
                zrun_d = zrun_q + 1'b1;
        end
        zrun_hit    = bus.din_valid && (zrun_d == ZRUN_MAX);
        seed_done   = bus.din_valid && (state_q == SEED) && (seed_cnt_q == SEED_LAST);
        verify_fail = bus.din_valid && (state_q == VERIFY) && bit_err;
        verify_done = bus.din_valid && (state_q == VERIFY) && !bit_err && (match_cnt_q == MATCH_LAST);
        err_hit     = bus.din_valid && (state_q == LOCKED) && bit_err;
        win_err_nxt = win_err_q + WERR_W'(err_hit);
        lock_loss   = err_hit && (win_err_nxt == THRESH);
        win_end     = bus.din_valid && (state_q == LOCKED) && (win_cnt_q == WIN_LAST);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            SEED:    if (seed_done) state_d = VERIFY;
            VERIFY:  if (verify_fail) state_d = SEED;
                     else if (verify_done) state_d = LOCKED;
            LOCKED:  if (lock_loss) state_d = SEED;
            default: state_d = SEED;
        endcase
        // A 31-zero run cannot occur in PRBS31, so treat it as a dead line.
        if (zrun_hit) state_d = SEED;
    end

    always_comb begin
        hist_d      = hist_q;
        seed_cnt_d  = seed_cnt_q;
        match_cnt_d = match_cnt_q;
        win_cnt_d   = win_cnt_q;
        win_err_d   = win_err_q;
        shift_bit   = bus.din;
`ifdef PRBS_FREEWHEEL_EN
        if (state_q == LOCKED) shift_bit = pred;
`endif
        if (bus.din_valid) begin
            hist_d = {hist_q[PRBS31_LEN-2:0], shift_bit};
            if (state_q == SEED)
                seed_cnt_d = seed_done ? '0 : seed_cnt_q + 1'b1;
            if (state_q == VERIFY)
                match_cnt_d = (verify_fail || verify_done) ? '0 : match_cnt_q + 1'b1;
            if (state_q == LOCKED) begin
                if (lock_loss || win_end) begin
                    win_cnt_d = '0;
                    win_err_d = '0;
                end else begin
                    win_cnt_d = win_cnt_q + 1'b1;
                    win_err_d = win_err_nxt;
                end
            end
        end
        if (zrun_hit) begin
            hist_d      = '0;
            seed_cnt_d  = '0;
            match_cnt_d = '0;
            win_cnt_d   = '0;
            win_err_d   = '0;
        end
        locked_d    = (state_d == LOCKED);
        err_pulse_d = err_hit;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= SEED;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q      <= '0;
            seed_cnt_q  <= '0;
            match_cnt_q <= '0;
            win_cnt_q   <= '0;
            win_err_q   <= '0;
            zrun_q      <= '0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
        end else begin
            hist_q      <= hist_d;
            seed_cnt_q  <= seed_cnt_d;
            match_cnt_q <= match_cnt_d;
            win_cnt_q   <= win_cnt_d;
            win_err_q   <= win_err_d;
            zrun_q      <= zrun_d;
            locked_q    <= locked_d;
            err_pulse_q <= err_pulse_d;
        end
    end

    prbs_sat_counter #(.WIDTH(ERR_W)) u_err_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (bus.err_clear),
        .inc   (err_hit),
        .cnt   (err_count)
    );

    assign bus.locked    = locked_q;
    assign bus.err_pulse = err_pulse_q;
    assign bus.err_count = err_count;
endmodule
